// File: rtl/alarm_ctrl_if.sv
// Pin bundle between the alarm panel and alarm_ctrl: raw request pins in,
// registered status and debug outputs back.
interface alarm_ctrl_if;
  logic       trip;
  logic       arm;
  logic       disarm;
  logic       siren;
  logic       armed;
  logic       pending;
  logic       alarm_mem;
  logic [2:0] state;

  modport master (
    output trip, arm, disarm,
    input  siren, armed, pending, alarm_mem, state
  );

  modport slave (
    input  trip, arm, disarm,
    output siren, armed, pending, alarm_mem, state
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Intruder alarm sequencer: synchronizes pin requests and steps through
// exit delay, armed watch, entry delay, timed siren and post-alarm hold.
module alarm_ctrl #(
  parameter int unsigned EXIT_DLY  = 16,
  parameter int unsigned ENTRY_DLY = 16,
  parameter int unsigned SIREN_LEN = 64
) (
  input logic         clk,
  input logic         rst_n,
  alarm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXITING  = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4,
    HOLD     = 3'd5
  } state_t;

  localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_DLY - 1);
  localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_DLY - 1);
  localparam logic [7:0] SIREN_LOAD = 8'(SIREN_LEN - 1);

  // {trip, arm, disarm} through two flop stages
  logic [2:0] sync_m;
  logic [2:0] sync_s;
  logic [1:0] prime;
  logic       arm_prev;
  logic       arm_ok;

  logic trip_s;
  logic arm_s;
  logic disarm_s;
  logic arm_rise;

  state_t     state_q;
  logic [7:0] cnt;
  logic       siren_q;
  logic       armed_q;
  logic       pending_q;
  logic       alarm_mem_q;

  assign trip_s   = sync_s[2];
  assign arm_s    = sync_s[1];
  assign disarm_s = sync_s[0];

  // arm_ok stays low until the synchronizer has really seen the pin low after
  // reset, so an arm pin already high at reset release never counts as a rise.
  assign arm_rise = arm_s & ~arm_prev & arm_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m   <= '0;
      sync_s   <= '0;
      prime    <= '0;
      arm_prev <= 1'b0;
      arm_ok   <= 1'b0;
    end else begin
      sync_m   <= {bus.trip, bus.arm, bus.disarm};
      sync_s   <= sync_m;
      prime    <= {prime[0], 1'b1};
      arm_prev <= arm_s;
      if (prime[1] && !arm_s) begin
        arm_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DISARMED;
      cnt         <= '0;
      siren_q     <= 1'b0;
      armed_q     <= 1'b0;
      pending_q   <= 1'b0;
      alarm_mem_q <= 1'b0;
    end else if (disarm_s) begin
      state_q   <= DISARMED;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (arm_rise) begin
            state_q     <= EXITING;
            cnt         <= EXIT_LOAD;
            pending_q   <= 1'b1;
            alarm_mem_q <= 1'b0;
          end
        end
        EXITING: begin
          if (cnt == 8'd0) begin
            state_q   <= ARMED;
            armed_q   <= 1'b1;
            pending_q <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ARMED: begin
          if (trip_s) begin
            state_q   <= ENTRY;
            cnt       <= ENTRY_LOAD;
            pending_q <= 1'b1;
          end
        end
        ENTRY: begin
          if (cnt == 8'd0) begin
            state_q     <= ALARM;
            cnt         <= SIREN_LOAD;
            siren_q     <= 1'b1;
            pending_q   <= 1'b0;
            alarm_mem_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ALARM: begin
          if (cnt == 8'd0) begin
            state_q <= HOLD;
            siren_q <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (trip_s) begin
            state_q <= ALARM;
            cnt     <= SIREN_LOAD;
            siren_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= DISARMED;
          siren_q   <= 1'b0;
          armed_q   <= 1'b0;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.siren     = siren_q;
  assign bus.armed     = armed_q;
  assign bus.pending   = pending_q;
  assign bus.alarm_mem = alarm_mem_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus queues expected output changes
// with their cycle stamps, monitors pop them whenever an output tuple changes.
module tb_alarm_ctrl;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  logic clk;
  logic rst0_n;
  logic rst1_n;
  logic trip;
  logic arm;
  logic disarm;
  int   cyc;
  int   total;
  int   bad;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [6:0] prev0;
  logic [6:0] prev1;

  alarm_ctrl_if bus0 ();
  alarm_ctrl_if bus1 ();

  assign bus0.trip   = trip;
  assign bus0.arm    = arm;
  assign bus0.disarm = disarm;
  assign bus1.trip   = trip;
  assign bus1.arm    = arm;
  assign bus1.disarm = disarm;

  alarm_ctrl dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus0)
  );

  alarm_ctrl #(
    .EXIT_DLY  (1),
    .ENTRY_DLY (1),
    .SIREN_LEN (1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // tuple = {state, siren, armed, pending, alarm_mem}
  function automatic logic [6:0] pk(input logic [2:0] st, input logic s,
                                    input logic a, input logic p, input logic m);
    return {st, s, a, p, m};
  endfunction

  task automatic expect_at(input int which, input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  task automatic chk(input string nm, input int which, input logic [6:0] cur);
    exp_t e;
    total++;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL %s: unexpected change to %b at cyc %0d", nm, cur, cyc);
    end else begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      if (cur !== e.v || cyc != e.cyc) begin
        bad++;
        $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d",
                 nm, cur, cyc, e.v, e.cyc);
      end
    end
  endtask

  task automatic chk_now(input string nm, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    prev0 = '0;
    prev1 = '0;
  end

  always @(negedge clk) begin
    logic [6:0] cur;
    cur = pk(bus0.state, bus0.siren, bus0.armed, bus0.pending, bus0.alarm_mem);
    if (cur !== prev0) begin
      chk("dut0", 0, cur);
      prev0 = cur;
    end
  end

  always @(negedge clk) begin
    logic [6:0] cur;
    cur = pk(bus1.state, bus1.siren, bus1.armed, bus1.pending, bus1.alarm_mem);
    if (cur !== prev1) begin
      chk("dut1", 1, cur);
      prev1 = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int d;
    total  = 0;
    bad    = 0;
    trip   = 1'b0;
    arm    = 1'b0;
    disarm = 1'b0;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    #1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    tick(3);
    chk_now("reset0", pk(bus0.state, bus0.siren, bus0.armed, bus0.pending, bus0.alarm_mem), 7'b0);
    rst0_n = 1'b1;
    tick(5);

    // arm pulse: exit delay then armed
    t = cyc;
    expect_at(0, t + 3,  pk(3'd1, 0, 0, 1, 0));
    expect_at(0, t + 19, pk(3'd2, 0, 1, 0, 0));
    arm = 1'b1;
    tick(4);
    arm = 1'b0;
    tick(30);

    // single-cycle trip: entry delay, full siren, hold
    t = cyc;
    expect_at(0, t + 3,  pk(3'd3, 0, 1, 1, 0));
    expect_at(0, t + 19, pk(3'd4, 1, 1, 0, 1));
    expect_at(0, t + 83, pk(3'd5, 0, 1, 0, 1));
    trip = 1'b1;
    tick(1);
    trip = 1'b0;
    tick(89);

    // retrigger from hold: straight to alarm for another full siren
    t = cyc;
    expect_at(0, t + 3,  pk(3'd4, 1, 1, 0, 1));
    expect_at(0, t + 67, pk(3'd5, 0, 1, 0, 1));
    trip = 1'b1;
    tick(2);
    trip = 1'b0;
    tick(73);

    // retrigger again, then disarm mid-siren keeps alarm_mem
    t = cyc;
    expect_at(0, t + 3, pk(3'd4, 1, 1, 0, 1));
    trip = 1'b1;
    tick(1);
    trip = 1'b0;
    tick(19);
    d = cyc;
    expect_at(0, d + 3, pk(3'd0, 0, 0, 0, 1));
    disarm = 1'b1;
    tick(2);
    disarm = 1'b0;
    tick(10);

    // re-arm clears alarm_mem on the arming edge
    t = cyc;
    expect_at(0, t + 3,  pk(3'd1, 0, 0, 1, 0));
    expect_at(0, t + 19, pk(3'd2, 0, 1, 0, 0));
    arm = 1'b1;
    tick(3);
    arm = 1'b0;
    tick(25);

    d = cyc;
    expect_at(0, d + 3, pk(3'd0, 0, 0, 0, 0));
    disarm = 1'b1;
    tick(2);
    disarm = 1'b0;
    tick(6);

    // trip held through the exit delay is ignored
    t = cyc;
    expect_at(0, t + 3,  pk(3'd1, 0, 0, 1, 0));
    expect_at(0, t + 19, pk(3'd2, 0, 1, 0, 0));
    arm  = 1'b1;
    trip = 1'b1;
    tick(3);
    arm = 1'b0;
    tick(14);
    trip = 1'b0;
    tick(10);

    // disarm with arm held: no re-arm while arm stays high
    d = cyc;
    expect_at(0, d + 3, pk(3'd0, 0, 0, 0, 0));
    arm    = 1'b1;
    disarm = 1'b1;
    tick(2);
    disarm = 1'b0;
    tick(100);
    chk_now("held_arm", pk(bus0.state, bus0.siren, bus0.armed, bus0.pending, bus0.alarm_mem), 7'b0);
    arm = 1'b0;
    tick(5);

    // arm and disarm together from disarmed
    arm    = 1'b1;
    disarm = 1'b1;
    tick(3);
    arm    = 1'b0;
    disarm = 1'b0;
    tick(10);
    chk_now("arm_and_disarm", pk(bus0.state, bus0.siren, bus0.armed, bus0.pending, bus0.alarm_mem), 7'b0);

    // into entry, then async reset with arm high
    t = cyc;
    expect_at(0, t + 3,  pk(3'd1, 0, 0, 1, 0));
    expect_at(0, t + 19, pk(3'd2, 0, 1, 0, 0));
    arm = 1'b1;
    tick(3);
    arm = 1'b0;
    tick(22);
    t = cyc;
    expect_at(0, t + 3, pk(3'd3, 0, 1, 1, 0));
    trip = 1'b1;
    tick(1);
    trip = 1'b0;
    tick(7);
    arm = 1'b1;
    tick(2);
    expect_at(0, cyc, pk(3'd0, 0, 0, 0, 0));
    #2;
    rst0_n = 1'b0;
    #1;
    chk_now("async_reset", pk(bus0.state, bus0.siren, bus0.armed, bus0.pending, bus0.alarm_mem), 7'b0);
    tick(3);
    rst0_n = 1'b1;
    tick(20);
    arm = 1'b0;
    chk_now("no_rise_at_release", pk(bus0.state, bus0.siren, bus0.armed, bus0.pending, bus0.alarm_mem), 7'b0);
    tick(5);

    // a fresh arm after reset works
    t = cyc;
    expect_at(0, t + 3, pk(3'd1, 0, 0, 1, 0));
    arm = 1'b1;
    tick(3);
    arm = 1'b0;
    tick(5);
    d = cyc;
    expect_at(0, d + 3, pk(3'd0, 0, 0, 0, 0));
    disarm = 1'b1;
    tick(2);
    disarm = 1'b0;
    tick(8);

    // minimal-delay instance: every timed state lasts one cycle
    rst0_n = 1'b0;
    chk_now("reset1", pk(bus1.state, bus1.siren, bus1.armed, bus1.pending, bus1.alarm_mem), 7'b0);
    rst1_n = 1'b1;
    tick(5);
    t = cyc;
    expect_at(1, t + 3, pk(3'd1, 0, 0, 1, 0));
    expect_at(1, t + 4, pk(3'd2, 0, 1, 0, 0));
    arm = 1'b1;
    tick(2);
    arm = 1'b0;
    tick(4);
    t = cyc;
    expect_at(1, t + 3, pk(3'd3, 0, 1, 1, 0));
    expect_at(1, t + 4, pk(3'd4, 1, 1, 0, 1));
    expect_at(1, t + 5, pk(3'd5, 0, 1, 0, 1));
    trip = 1'b1;
    tick(1);
    trip = 1'b0;
    tick(10);
    t = cyc;
    expect_at(1, t + 3, pk(3'd4, 1, 1, 0, 1));
    expect_at(1, t + 4, pk(3'd5, 0, 1, 0, 1));
    trip = 1'b1;
    tick(1);
    trip = 1'b0;
    tick(8);
    d = cyc;
    expect_at(1, d + 3, pk(3'd0, 0, 0, 0, 1));
    disarm = 1'b1;
    tick(2);
    disarm = 1'b0;
    tick(8);

    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL leftover0: %0d expected changes never seen, want 0", q0.size());
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL leftover1: %0d expected changes never seen, want 0", q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter EXIT_DLY, default 16, exit-delay length in clock cycles (legal 1..255).
REQ-002 Parameter ENTRY_DLY, default 16, entry-delay length in clock cycles (legal 1..255).
REQ-003 Parameter SIREN_LEN, default 64, siren-on length in clock cycles (legal 1..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 trip  input  1  level alarm condition from the combinational sensor-voting stage; asynchronous to clk.
REQ-007 arm  input  1  level arm request from pin; asynchronous.
REQ-008 disarm  input  1  level disarm request from pin; asynchronous.
REQ-009 siren  output  1  siren drive, high only in ALARM.
REQ-010 armed  output  1  high in ARMED, ENTRY, ALARM, HOLD.
REQ-011 pending  output  1  beeper; high in EXITING or ENTRY.
REQ-012 alarm_mem  output  1  sticky flag: an alarm has fired since last arm.
REQ-013 state  output  3  current FSM encoding, for debug pins.

Function
REQ-014 trip, arm, disarm SHALL each pass through a 2-flop synchronizer; FSM uses only synchronized copies (trip_s, arm_s, disarm_s).
REQ-015 An input held high across rising edges k, k+1 SHALL cause the FSM state change visible after edge k+2 (3-edge latency).
REQ-016 arm_rise = arm_s high and its previous-cycle value low; only arm_rise arms; a held arm SHALL not re-arm.
REQ-017 States and encodings: DISARMED=0, EXITING=1, ARMED=2, ENTRY=3, ALARM=4, HOLD=5; codes 6,7 SHALL go to DISARMED next edge.
REQ-018 A single 8-bit down-counter SHALL time EXITING, ENTRY and ALARM; loaded with the parameter minus 1 on state entry.
REQ-019 DISARMED: arm_rise -> EXITING, alarm_mem cleared to 0 on same edge.
REQ-020 EXITING: trip_s ignored; SHALL last exactly EXIT_DLY cycles, then ARMED.
REQ-021 ARMED: trip_s high -> ENTRY.
REQ-022 ENTRY: SHALL last exactly ENTRY_DLY cycles, then ALARM, regardless of trip_s deasserting.
REQ-023 ALARM: siren=1, alarm_mem set to 1 on entry; SHALL last exactly SIREN_LEN cycles, then HOLD.
REQ-024 HOLD: siren=0; trip_s high -> ALARM directly (no entry delay), counter reloaded.
REQ-025 disarm_s high in any state SHALL force DISARMED on the next edge; siren drops same edge; alarm_mem retained.
REQ-026 disarm_s and arm_rise in the same cycle: disarm wins, state DISARMED, alarm_mem unchanged.
REQ-027 arm_rise outside DISARMED SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from registered state only; no path from pins to outputs without the synchronizer.

Reset
REQ-029 rst_n low SHALL immediately (no clock) force state=DISARMED, counter=0, synchronizer flops=0, arm_s history=0, alarm_mem=0, siren=0, armed=0, pending=0.
REQ-030 Reset asserted mid-ALARM SHALL drop siren asynchronously; after release FSM SHALL wait for a fresh arm_rise.
REQ-031 Deassertion of rst_n SHALL not itself create an arm_rise, even if arm is high at release.

Verification
REQ-032 Arm pulse 4 cycles, defaults -> state 1 after 3 edges, pending=1 for 16 cycles, then state 2, armed=1, pending=0.
REQ-033 From ARMED, trip high 1 cycle -> state 3 after 3 edges, 16 cycles, then state 4 siren=1 for exactly 64 cycles, then state 5, siren=0, alarm_mem=1.
REQ-034 In HOLD, trip high -> state 4 after 3 edges, siren 64 more cycles; disarm during siren -> state 0 next edge after sync, siren=0, alarm_mem=1; re-arm -> alarm_mem=0.
REQ-035 During EXITING, trip held high -> no ENTRY; arm held high 100 cycles after DISARMED return -> stays state 0.
REQ-036 arm and disarm asserted same cycle from DISARMED -> state stays 0; rst_n pulsed low mid-ENTRY with arm high -> all outputs 0 immediately, state 0 after release.
REQ-037 Parameter override EXIT_DLY=1, ENTRY_DLY=1, SIREN_LEN=1 -> each timed state lasts exactly 1 cycle.
